fcore_efi_dma_engine: RTL and testbench
=======================================

Name: fcore_efi_dma_engine

Overview:
- Parametrised next-generation fCore EFI argument/result mover, placed between the fCore register file and an external function interface (EFI) accelerator.
- On a call request it streams `length` argument words from the calling channel's register window to the EFI. It then writes the returned results back to the channel's return window.
- Over the previous handler it adds: `efi_arguments.ready` backpressure, configurable memory read latency, length checking, result timeout, and busy/done/error status.

Parameters:
- DATAPATH_WIDTH, 32, register/data word width
- REG_ADDR_WIDTH, 8, register file address width
- BASE_REG_ADDR_WIDTH, 4, log2 of per-channel register window size
- CH_ADDRESS_WIDTH, 8, channel index width
- MEM_READ_LATENCY, 1, cycles from mem_address to valid mem_read_data (>=1)
- MAX_LENGTH, 16, largest accepted argument count (<=255)
- TIMEOUT_CYCLES, 1024, idle cycles allowed between result beats

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- send_arguments  in  1  call request, sampled only in IDLE
- arguments_base_address  in  REG_ADDR_WIDTH  first argument register within window
- return_base_address  in  REG_ADDR_WIDTH  first result register within window
- channel_address  in  CH_ADDRESS_WIDTH  calling channel
- length  in  8  argument count
- busy  out  1  high from acceptance until return to IDLE
- done  out  1  one-cycle pulse on normal completion
- length_error  out  1  one-cycle pulse on rejected length
- timeout_error  out  1  one-cycle pulse on result timeout
- mem_efi_enable  out  2  0 none, 1 EFI read port, 3 EFI write port
- mem_address  out  REG_ADDR_WIDTH  register file read address
- mem_read_data  in  DATAPATH_WIDTH  register file read data
- efi_arguments  axi_stream.master  data/dest/valid/ready/tlast
- efi_results  axi_stream.slave  data/dest/valid/ready/tlast
- result_writeback  axi_stream.master  data/dest/valid (no ready; register file always accepts)

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset values: all outputs 0, FSM in IDLE, all counters and the FIFO cleared.
- Reset mid-operation aborts the call immediately. No done or error pulse is produced and partial results are not written.
- Address arithmetic: addr = base + index + (channel << BASE_REG_ADDR_WIDTH), truncated to REG_ADDR_WIDTH. Wrap-around is silent.
- IDLE:
  - On send_arguments, latch all request inputs.
  - length==0: pulse done next cycle, no transfers, stay IDLE.
  - length>MAX_LENGTH: pulse length_error next cycle, stay IDLE.
  - Otherwise go to SEND; busy=1 from the next cycle.
- SEND:
  - mem_efi_enable=1.
  - Reads are issued at index 0..length-1. Returned data lands in an argument FIFO of depth MEM_READ_LATENCY+1.
  - A read is issued only when (outstanding reads + FIFO occupancy) < depth, so the FIFO never overflows.
  - efi_arguments.valid = FIFO not empty; data = FIFO head; dest = argument index (0-based); tlast on index length-1.
  - A beat transfers when valid && ready. valid and data must be held stable while ready=0.
  - With ready held high, beats are back-to-back; the first beat appears MEM_READ_LATENCY+1 cycles after entering SEND.
  - After the tlast beat transfers, go to WAIT.
- WAIT:
  - efi_results.ready=1; timeout counter cleared on entry and on every result beat.
  - Each result beat: next cycle result_writeback.valid=1 for one cycle with data = efi_results.data. dest = return_base + efi_results.dest + (channel << BASE_REG_ADDR_WIDTH), and mem_efi_enable=3 in that same cycle; otherwise mem_efi_enable=0.
  - Back-to-back result beats produce back-to-back writebacks.
  - The beat with tlast: after its writeback, pulse done, busy=0, go to IDLE.
  - Counter reaching TIMEOUT_CYCLES: pulse timeout_error, busy=0, IDLE.
- efi_results.ready=0 outside WAIT; result beats presented then are not consumed.
- send_arguments while busy is ignored; no queueing.

Test Plan:
- ch=2, args_base=3, length=4, BASE_REG_ADDR_WIDTH=4, ready=1 -> reads 35,36,37,38; EFI beats dest 0..3 back-to-back, tlast on dest 3; busy high throughout.
- Same call with ready toggling 1,0,0,1 repeatedly -> no lost or duplicated beats, data stable while stalled; re-run with MEM_READ_LATENCY=3 -> FIFO occupancy never exceeds 4.
- Results dest 0,1 (tlast on 1), return_base=8, ch=2 -> writebacks to 40 then 41 with mem_efi_enable=3 in each, then done pulse, busy=0.
- length=0 -> done only, no mem reads; length=17 with MAX_LENGTH=16 -> length_error only, FSM stays IDLE.
- No results for TIMEOUT_CYCLES=1024 cycles after the last argument -> timeout_error pulse at cycle 1024, FSM back in IDLE, next call accepted.
- Reset asserted during the third argument beat -> all outputs 0 next cycle, no done pulse; a new call afterwards starts at dest 0.

Source files
------------

// File: rtl/fcore_efi_dma_engine_if.sv
// rtl/fcore_efi_dma_engine_if.sv - stream bundle for EFI argument, result and writeback paths
// Writeback has no ready: the register file always accepts.
interface fcore_efi_dma_engine_if #(
   parameter int DATA_WIDTH = 32,
   parameter int DEST_WIDTH = 8
);
   logic [DATA_WIDTH-1:0] data;
   logic [DEST_WIDTH-1:0] dest;
   logic                  valid;
   logic                  ready;
   logic                  tlast;

   modport master    (output data, dest, valid, tlast, input ready);
   modport slave     (input data, dest, valid, tlast, output ready);
   modport writeback (output data, dest, valid);
endinterface

// File: rtl/fcore_efi_dma_engine.sv
// rtl/fcore_efi_dma_engine.sv - fCore EFI argument/result mover
// Streams argument registers to the EFI, then writes returned results into the channel window.
module fcore_efi_dma_engine #(
   parameter int DATAPATH_WIDTH      = 32,
   parameter int REG_ADDR_WIDTH      = 8,
   parameter int BASE_REG_ADDR_WIDTH = 4,
   parameter int CH_ADDRESS_WIDTH    = 8,
   parameter int MEM_READ_LATENCY    = 1,
   parameter int MAX_LENGTH          = 16,
   parameter int TIMEOUT_CYCLES      = 1024
) (
   input  logic                        clock,
   input  logic                        reset,
   input  logic                        send_arguments,
   input  logic [REG_ADDR_WIDTH-1:0]   arguments_base_address,
   input  logic [REG_ADDR_WIDTH-1:0]   return_base_address,
   input  logic [CH_ADDRESS_WIDTH-1:0] channel_address,
   input  logic [7:0]                  length,
   output logic                        busy,
   output logic                        done,
   output logic                        length_error,
   output logic                        timeout_error,
   output logic [1:0]                  mem_efi_enable,
   output logic [REG_ADDR_WIDTH-1:0]   mem_address,
   input  logic [DATAPATH_WIDTH-1:0]   mem_read_data,
   fcore_efi_dma_engine_if.master      efi_arguments,
   fcore_efi_dma_engine_if.slave       efi_results,
   fcore_efi_dma_engine_if.writeback   result_writeback
);
   localparam int DEPTH = MEM_READ_LATENCY + 1;
   localparam int CNT_W = $clog2(DEPTH + 2);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_SEND = 2'd1;
   localparam logic [1:0] S_WAIT = 2'd2;
   localparam logic [1:0] S_LAST = 2'd3;

   logic [1:0]                  state_q, state_d;
   logic [REG_ADDR_WIDTH-1:0]   args_base_q, args_base_d, ret_base_q, ret_base_d;
   logic [CH_ADDRESS_WIDTH-1:0] ch_q, ch_d;
   logic [7:0]                  len_q, len_d, rd_idx_q, rd_idx_d, tx_idx_q, tx_idx_d;
   logic [CNT_W-1:0]            out_cnt_q, out_cnt_d, fifo_cnt_q, fifo_cnt_d;
   logic [PTR_W-1:0]            wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [DATAPATH_WIDTH-1:0]   fifo_mem_q [DEPTH];
   logic [DATAPATH_WIDTH-1:0]   fifo_mem_d [DEPTH];
   logic [MEM_READ_LATENCY-1:0] pipe_q, pipe_d;
   logic [TMO_W-1:0]            tmo_q, tmo_d;
   logic                        done_q, done_d, len_err_q, len_err_d, tmo_err_q, tmo_err_d;
   logic                        wb_valid_q, wb_valid_d;
   logic [DATAPATH_WIDTH-1:0]   wb_data_q, wb_data_d;
   logic [REG_ADDR_WIDTH-1:0]   wb_dest_q, wb_dest_d;

   logic [REG_ADDR_WIDTH-1:0]   ch_off;
   logic [CNT_W-1:0]            slots_used;
   logic                        arg_fire, arg_last, res_fire, issue, capture;

   assign ch_off   = REG_ADDR_WIDTH'(ch_q) << BASE_REG_ADDR_WIDTH;
   assign arg_last = (tx_idx_q == len_q - 8'd1);
   assign arg_fire = efi_arguments.valid && efi_arguments.ready;
   assign res_fire = efi_results.valid && efi_results.ready;
   assign capture  = pipe_q[MEM_READ_LATENCY-1];
   // A slot freed by this cycle's pop is reusable now, which keeps beats back-to-back.
   assign slots_used = out_cnt_q + fifo_cnt_q - CNT_W'(arg_fire);
   assign issue      = (state_q == S_SEND) && (rd_idx_q < len_q) && (slots_used < CNT_W'(DEPTH));

   assign efi_arguments.valid = (state_q == S_SEND) && (fifo_cnt_q != '0);
   assign efi_arguments.data  = fifo_mem_q[rd_ptr_q];
   assign efi_arguments.dest  = (state_q == S_SEND) ? REG_ADDR_WIDTH'(tx_idx_q) : '0;
   assign efi_arguments.tlast = (state_q == S_SEND) && arg_last;
   assign efi_results.ready   = (state_q == S_WAIT);

   assign result_writeback.valid = wb_valid_q;
   assign result_writeback.data  = wb_data_q;
   assign result_writeback.dest  = wb_dest_q;

   assign busy           = (state_q != S_IDLE);
   assign done           = done_q;
   assign length_error   = len_err_q;
   assign timeout_error  = tmo_err_q;
   assign mem_efi_enable = (state_q == S_SEND) ? 2'd1 : (wb_valid_q ? 2'd3 : 2'd0);
   assign mem_address    = (state_q == S_SEND) ? args_base_q + REG_ADDR_WIDTH'(rd_idx_q) + ch_off : '0;

   always_comb begin
      state_d     = state_q;
      args_base_d = args_base_q;
      ret_base_d  = ret_base_q;
      ch_d        = ch_q;
      len_d       = len_q;
      tmo_d       = tmo_q;
      done_d      = 1'b0;
      len_err_d   = 1'b0;
      tmo_err_d   = 1'b0;
      wb_valid_d  = 1'b0;
      wb_data_d   = wb_data_q;
      wb_dest_d   = wb_dest_q;
      fifo_mem_d  = fifo_mem_q;

      pipe_d     = pipe_q << 1;
      pipe_d[0]  = issue;
      rd_idx_d   = rd_idx_q + 8'(issue);
      tx_idx_d   = tx_idx_q + 8'(arg_fire);
      out_cnt_d  = out_cnt_q + CNT_W'(issue) - CNT_W'(capture);
      fifo_cnt_d = fifo_cnt_q + CNT_W'(capture) - CNT_W'(arg_fire);
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      if (capture) begin
         fifo_mem_d[wr_ptr_q] = mem_read_data;
         wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
      end
      if (arg_fire) begin
         rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
      end

      case (state_q)
         S_IDLE: begin
            if (send_arguments) begin
               args_base_d = arguments_base_address;
               ret_base_d  = return_base_address;
               ch_d        = channel_address;
               len_d       = length;
               rd_idx_d    = '0;
               tx_idx_d    = '0;
               out_cnt_d   = '0;
               fifo_cnt_d  = '0;
               wr_ptr_d    = '0;
               rd_ptr_d    = '0;
               pipe_d      = '0;
               if (length == 8'd0)                 done_d    = 1'b1;
               else if (length > 8'(MAX_LENGTH))   len_err_d = 1'b1;
               else                                state_d   = S_SEND;
            end
         end
         S_SEND: begin
            if (arg_fire && arg_last) begin
               state_d = S_WAIT;
               tmo_d   = '0;
            end
         end
         S_WAIT: begin
            if (res_fire) begin
               wb_valid_d = 1'b1;
               wb_data_d  = efi_results.data;
               wb_dest_d  = ret_base_q + efi_results.dest + ch_off;
               tmo_d      = '0;
               if (efi_results.tlast) state_d = S_LAST;
            end else if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
               state_d   = S_IDLE;
               tmo_err_d = 1'b1;
            end else begin
               tmo_d = tmo_q + 1'b1;
            end
         end
         default: begin
            // Final writeback is on the bus this cycle; completion follows it.
            state_d = S_IDLE;
            done_d  = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= S_IDLE;
         args_base_q <= '0;
         ret_base_q  <= '0;
         ch_q        <= '0;
         len_q       <= '0;
         rd_idx_q    <= '0;
         tx_idx_q    <= '0;
         out_cnt_q   <= '0;
         fifo_cnt_q  <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         fifo_mem_q  <= '{default: '0};
         pipe_q      <= '0;
         tmo_q       <= '0;
         done_q      <= 1'b0;
         len_err_q   <= 1'b0;
         tmo_err_q   <= 1'b0;
         wb_valid_q  <= 1'b0;
         wb_data_q   <= '0;
         wb_dest_q   <= '0;
      end else begin
         state_q     <= state_d;
         args_base_q <= args_base_d;
         ret_base_q  <= ret_base_d;
         ch_q        <= ch_d;
         len_q       <= len_d;
         rd_idx_q    <= rd_idx_d;
         tx_idx_q    <= tx_idx_d;
         out_cnt_q   <= out_cnt_d;
         fifo_cnt_q  <= fifo_cnt_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         fifo_mem_q  <= fifo_mem_d;
         pipe_q      <= pipe_d;
         tmo_q       <= tmo_d;
         done_q      <= done_d;
         len_err_q   <= len_err_d;
         tmo_err_q   <= tmo_err_d;
         wb_valid_q  <= wb_valid_d;
         wb_data_q   <= wb_data_d;
         wb_dest_q   <= wb_dest_d;
      end
   end
endmodule

// File: tb/tb_fcore_efi_dma_engine.sv
// tb/tb_fcore_efi_dma_engine.sv - directed scoreboard bench for fcore_efi_dma_engine
module tb_fcore_efi_dma_engine;
   localparam int LAT = 3;

   typedef struct packed {
      logic [31:0] data;
      logic [7:0]  dest;
      logic        last;
   } arg_t;
   typedef struct packed {
      logic [31:0] data;
      logic [7:0]  dest;
   } wb_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        send = 1'b0;
   logic [7:0]  abase = '0, rbase = '0, chan = '0, len = '0;
   logic        busy, done, length_error, timeout_error;
   logic [1:0]  mem_en;
   logic [7:0]  mem_addr;
   logic [31:0] mem_rdata;
   logic [7:0]  apipe [LAT];

   int   n_checks = 0;
   int   n_fail   = 0;
   int   done_cnt = 0;
   int   ph       = 0;
   bit   rdy_mode = 1'b0;
   arg_t arg_q [$];
   wb_t  wb_q  [$];
   bit          hold_q = 1'b0;
   logic [31:0] hold_data;
   logic [7:0]  hold_dest;

   fcore_efi_dma_engine_if #(.DATA_WIDTH(32), .DEST_WIDTH(8)) args_if ();
   fcore_efi_dma_engine_if #(.DATA_WIDTH(32), .DEST_WIDTH(8)) res_if ();
   fcore_efi_dma_engine_if #(.DATA_WIDTH(32), .DEST_WIDTH(8)) wb_if ();

   fcore_efi_dma_engine #(
      .DATAPATH_WIDTH(32), .REG_ADDR_WIDTH(8), .BASE_REG_ADDR_WIDTH(4), .CH_ADDRESS_WIDTH(8),
      .MEM_READ_LATENCY(LAT), .MAX_LENGTH(16), .TIMEOUT_CYCLES(1024)
   ) dut (
      .clock(clk), .reset(rst), .send_arguments(send),
      .arguments_base_address(abase), .return_base_address(rbase),
      .channel_address(chan), .length(len),
      .busy(busy), .done(done), .length_error(length_error), .timeout_error(timeout_error),
      .mem_efi_enable(mem_en), .mem_address(mem_addr), .mem_read_data(mem_rdata),
      .efi_arguments(args_if), .efi_results(res_if), .result_writeback(wb_if)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] rf(input logic [7:0] a);
      return {8'hC3, a, ~a, a ^ 8'h5A};
   endfunction

   always @(posedge clk) begin
      apipe[0] <= mem_addr;
      for (int i = 1; i < LAT; i++) apipe[i] <= apipe[i-1];
   end
   assign mem_rdata = rf(apipe[LAT-1]);

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      args_if.ready = rdy_mode ? ((ph % 4 == 0) || (ph % 4 == 3)) : 1'b1;
      ph++;
   endtask

   task automatic call(input logic [7:0] c, input logic [7:0] ab, input logic [7:0] rb, input logic [7:0] n);
      if (n != 0 && n <= 16)
         for (int i = 0; i < n; i++)
            arg_q.push_back('{rf(ab + 8'(i) + (c << 4)), 8'(i), (i == n - 1)});
      chan = c; abase = ab; rbase = rb; len = n; send = 1'b1;
      tick();
      send = 1'b0;
   endtask

   task automatic result(input logic [7:0] d, input logic [31:0] v, input logic last, input logic [7:0] exp_addr);
      wb_q.push_back('{v, exp_addr});
      res_if.valid = 1'b1; res_if.dest = d; res_if.data = v; res_if.tlast = last;
      tick();
      res_if.valid = 1'b0; res_if.tlast = 1'b0;
   endtask

   // Scoreboard monitors, sampled mid-cycle.
   always @(negedge clk) begin
      if (hold_q) begin
         check("arg_hold_valid", args_if.valid, 1'b1);
         check("arg_hold_data", args_if.data, hold_data);
         check("arg_hold_dest", args_if.dest, hold_dest);
      end
      hold_q    <= args_if.valid && !args_if.ready && !rst;
      hold_data <= args_if.data;
      hold_dest <= args_if.dest;
      if (args_if.valid && args_if.ready) begin
         if (arg_q.size() == 0) check("arg_unexpected", arg_q.size(), 1);
         else begin
            arg_t e;
            e = arg_q.pop_front();
            check("arg_data", args_if.data, e.data);
            check("arg_dest", args_if.dest, e.dest);
            check("arg_last", args_if.tlast, e.last);
         end
      end
      if (wb_if.valid) begin
         check("wb_enable", mem_en, 2'd3);
         if (wb_q.size() == 0) check("wb_unexpected", wb_q.size(), 1);
         else begin
            wb_t w;
            w = wb_q.pop_front();
            check("wb_data", wb_if.data, w.data);
            check("wb_dest", wb_if.dest, w.dest);
         end
      end
      if (done) done_cnt <= done_cnt + 1;
   end

   initial begin
      int cnt;
      int done_before;
      args_if.ready = 1'b1;
      res_if.valid = 1'b0; res_if.dest = '0; res_if.data = '0; res_if.tlast = 1'b0;
      wb_if.ready = 1'b0; wb_if.tlast = 1'b0;
      repeat (3) tick();

      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_len_err", length_error, 0);
      check("rst_tmo_err", timeout_error, 0);
      check("rst_mem_en", mem_en, 0);
      check("rst_mem_addr", mem_addr, 0);
      check("rst_arg_valid", args_if.valid, 0);
      check("rst_res_ready", res_if.ready, 0);
      check("rst_wb_valid", wb_if.valid, 0);
      rst = 1'b0;
      tick();

      // Straight call, ready held high.
      call(8'd2, 8'd3, 8'd8, 8'd4);
      check("send_busy", busy, 1);
      check("send_mem_en", mem_en, 1);
      check("send_first_addr", mem_addr, 35);
      check("send_res_ready", res_if.ready, 0);
      cnt = 0;
      while (!args_if.valid && cnt < 20) begin tick(); cnt++; end
      check("first_beat_latency", cnt, LAT + 1);
      repeat (4) tick();
      check("b2b_all_sent", arg_q.size(), 0);
      check("wait_res_ready", res_if.ready, 1);
      check("wait_busy", busy, 1);
      result(8'd0, 32'hDEAD_0001, 1'b0, 8'd40);
      result(8'd1, 32'hBEEF_0002, 1'b1, 8'd41);
      cnt = 0;
      while (!done && cnt < 10) begin tick(); cnt++; end
      check("call1_done", done, 1);
      check("call1_busy_after", busy, 0);
      check("call1_wb_drained", wb_q.size(), 0);

      // Stalling ready, then no results until timeout.
      rdy_mode = 1'b1;
      call(8'd5, 8'd14, 8'd0, 8'd7);
      cnt = 0;
      while (!res_if.ready && cnt < 200) begin tick(); cnt++; end
      check("stall_reached_wait", res_if.ready, 1);
      check("stall_all_sent", arg_q.size(), 0);
      done_before = done_cnt;
      cnt = 0;
      while (!timeout_error && cnt < 1100) begin tick(); cnt++; end
      check("timeout_cycle", cnt, 1024);
      check("timeout_busy", busy, 0);
      check("timeout_res_ready", res_if.ready, 0);
      check("timeout_no_done", done_cnt, done_before);
      rdy_mode = 1'b0;
      tick();

      // Length boundaries.
      call(8'd1, 8'd0, 8'd0, 8'd0);
      check("len0_done", done, 1);
      check("len0_busy", busy, 0);
      check("len0_mem_en", mem_en, 0);
      tick();
      check("len0_done_pulse", done, 0);
      call(8'd1, 8'd0, 8'd0, 8'd17);
      check("len17_err", length_error, 1);
      check("len17_done", done, 0);
      check("len17_busy", busy, 0);
      tick();
      check("len17_err_pulse", length_error, 0);
      check("len17_idle", busy, 0);

      // Reset during the third argument beat.
      call(8'd0, 8'd0, 8'd0, 8'd5);
      cnt = 0;
      while (!(args_if.valid && args_if.dest == 8'd2) && cnt < 20) begin tick(); cnt++; end
      check("third_beat_seen", args_if.dest, 2);
      rst = 1'b1;
      done_before = done_cnt;
      tick();
      check("midrst_busy", busy, 0);
      check("midrst_mem_en", mem_en, 0);
      check("midrst_mem_addr", mem_addr, 0);
      check("midrst_arg_valid", args_if.valid, 0);
      check("midrst_wb_valid", wb_if.valid, 0);
      check("midrst_res_ready", res_if.ready, 0);
      rst = 1'b0;
      arg_q.delete();
      repeat (3) tick();
      check("midrst_no_done", done_cnt, done_before);
      call(8'd3, 8'd1, 8'd5, 8'd2);
      cnt = 0;
      while (!res_if.ready && cnt < 50) begin tick(); cnt++; end
      check("post_rst_sent", arg_q.size(), 0);
      result(8'd0, 32'h0123_4567, 1'b1, 8'd53);
      cnt = 0;
      while (!done && cnt < 10) begin tick(); cnt++; end
      check("post_rst_done", done, 1);
      check("post_rst_wb_drained", wb_q.size(), 0);
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
